trap_ctrl: RTL and testbench
============================

// Module: trap_ctrl
// PURPOSE
//  Trap sequencer between EX stage and the CSR file. On ECALL it stalls the pipe,
//  drains outstanding memory ops, pulses the CSR file to record mepc/mcause,
//  then flushes and redirects fetch to mtvec. MRET redirects fetch to mepc.
//  Consumes the CSR file's mepc/mtvec outputs; produces its trap write strobe.
// PARAMETERS
//  DRAIN_MAX  15  max DRAIN cycles before forced commit (4-bit counter, 1..15)
// PORTS
//  clk             in   1   clock; all logic on posedge
//  rst             in   1   synchronous reset, active-high
//  ex_valid        in   1   EX holds a valid instruction
//  ex_is_ecall     in   1   EX instruction is ECALL
//  ex_is_mret      in   1   EX instruction is MRET
//  ex_pc           in   32  PC of EX instruction
//  mem_busy        in   1   LSU has an outstanding access
//  mepc            in   32  current mepc from CSR file
//  mtvec           in   32  current mtvec from CSR file
//  stall           out  1   freeze IF/ID/EX
//  flush           out  1   kill IF/ID/EX contents (1-cycle pulse)
//  redirect_valid  out  1   fetch redirect strobe (1-cycle pulse)
//  redirect_pc     out  32  redirect target
//  csr_trap_we     out  1   CSR file trap write (mepc<=trap_pc, mcause<=trap_cause)
//  trap_pc         out  32  PC of trapping instruction
//  trap_cause      out  32  mcause value for csr_trap_we
//  busy            out  1   FSM not IDLE
//  drain_timeout   out  1   sticky: a DRAIN hit DRAIN_MAX
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; trap_pc/redirect_pc/trap_cause regs 0;
//   drain_timeout cleared. Reset in any state aborts the sequence, no strobes.
//  accept = (state==IDLE) & ex_valid & (ex_is_ecall | ex_is_mret).
//  stall = accept | (state inside {DRAIN, COMMIT}); comb.
//  IDLE: ecall accept -> latch trap_pc<=ex_pc, trap_cause<=11, cnt<=0 -> DRAIN.
//   mret accept -> latch redirect_pc<={mepc[31:2],2'b00} -> REDIRECT.
//   ecall & mret both set -> ecall wins. ex_* ignored outside IDLE.
//  DRAIN: mem_busy==0 -> COMMIT. Else cnt++; cnt==DRAIN_MAX-1 with mem_busy
//   still 1 -> set drain_timeout, go COMMIT anyway. busy=1.
//  COMMIT: csr_trap_we=1 exactly this cycle; latch
//   redirect_pc<={mtvec[31:2],2'b00} (mtvec sampled here, direct mode only)
//   -> REDIRECT.
//  REDIRECT: redirect_valid=1, flush=1, stall=0 for one cycle -> IDLE.
//  Latency (mem_busy=0): ECALL accept c0, DRAIN c1, COMMIT c2, REDIRECT c3.
//   MRET accept c0, REDIRECT c1. New accept possible in the cycle after REDIRECT.
//  redirect_pc/trap_pc/trap_cause hold last value when not strobed.
//  drain_timeout clears only on rst.
// CONFIGURATION
//  TRAP_EBREAK_EN defined: adds input ex_is_ebreak (1b). EBREAK takes the ECALL
//   path with trap_cause=3; priority ecall > ebreak > mret.
//  Undefined: port absent; EBREAK not recognised (treated as ordinary instr).
// TESTING
//  ECALL ex_pc=0x100, mtvec=0x805, mem_busy=0 -> stall c0-c2, csr_trap_we c2
//   with trap_pc=0x100/trap_cause=11, redirect_valid+flush c3, redirect_pc=0x804.
//  ECALL with mem_busy high 4 cycles -> COMMIT delayed 4 cycles, no timeout.
//  ECALL, mem_busy stuck 1, DRAIN_MAX=15 -> drain_timeout=1, csr_trap_we still
//   pulses once, redirect follows; stays 1 until rst.
//  MRET mepc=0x204 -> redirect_valid c1, redirect_pc=0x204, no csr_trap_we.
//  ECALL+MRET same cycle -> ECALL path; rst asserted in DRAIN -> IDLE next
//   cycle, no csr_trap_we/redirect ever.
//  TRAP_EBREAK_EN: EBREAK pc=0x40 -> csr_trap_we with trap_cause=3, trap_pc=0x40.

Source files
------------

// File: rtl/trap_ctrl.sv
// Trap sequencer: ECALL stall/drain/commit/redirect, MRET redirect to mepc.
// Define TRAP_EBREAK_EN to add the ex_is_ebreak input (EBREAK, mcause 3).
module trap_ctrl #(
  parameter int unsigned DRAIN_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_is_ecall,
  input  logic        ex_is_mret,
`ifdef TRAP_EBREAK_EN
  input  logic        ex_is_ebreak,
`endif
  input  logic [31:0] ex_pc,
  input  logic        mem_busy,
  input  logic [31:0] mepc,
  input  logic [31:0] mtvec,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        csr_trap_we,
  output logic [31:0] trap_pc,
  output logic [31:0] trap_cause,
  output logic        busy,
  output logic        drain_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    COMMIT,
    REDIRECT
  } state_e;

  localparam logic [3:0]  CNT_LAST = 4'(DRAIN_MAX - 1);
  localparam logic [31:0] ALIGN    = 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic [31:0] trap_cause_q, trap_cause_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        timeout_q, timeout_d;

  logic        trap_req;
  logic        accept;
  logic [31:0] cause_sel;
  logic        stall_c, flush_c, rv_c, we_c;

`ifdef TRAP_EBREAK_EN
  assign trap_req  = ex_is_ecall | ex_is_ebreak;
  assign cause_sel = ex_is_ecall ? 32'd11 : 32'd3;
`else
  assign trap_req  = ex_is_ecall;
  assign cause_sel = 32'd11;
`endif

  assign accept = (state_q == IDLE) & ex_valid & (trap_req | ex_is_mret);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    trap_pc_d     = trap_pc_q;
    trap_cause_d  = trap_cause_q;
    redirect_pc_d = redirect_pc_q;
    timeout_d     = timeout_q;
    stall_c       = 1'b0;
    flush_c       = 1'b0;
    rv_c          = 1'b0;
    we_c          = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_c = accept;
        if (accept) begin
          if (trap_req) begin
            trap_pc_d    = ex_pc;
            trap_cause_d = cause_sel;
            cnt_d        = '0;
            state_d      = DRAIN;
          end else begin
            redirect_pc_d = mepc & ALIGN;
            state_d       = REDIRECT;
          end
        end
      end
      DRAIN: begin
        stall_c = 1'b1;
        if (!mem_busy) begin
          state_d = COMMIT;
        end else if (cnt_q == CNT_LAST) begin
          // LSU never went idle: commit anyway and flag it
          timeout_d = 1'b1;
          state_d   = COMMIT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      COMMIT: begin
        stall_c       = 1'b1;
        we_c          = 1'b1;
        redirect_pc_d = mtvec & ALIGN;
        state_d       = REDIRECT;
      end
      REDIRECT: begin
        rv_c    = 1'b1;
        flush_c = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      trap_pc_q     <= '0;
      trap_cause_q  <= '0;
      redirect_pc_q <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      trap_pc_q     <= trap_pc_d;
      trap_cause_q  <= trap_cause_d;
      redirect_pc_q <= redirect_pc_d;
      timeout_q     <= timeout_d;
    end
  end

  // strobes are suppressed while reset is asserted
  assign stall          = stall_c & ~rst;
  assign flush          = flush_c & ~rst;
  assign redirect_valid = rv_c & ~rst;
  assign csr_trap_we    = we_c & ~rst;
  assign busy           = (state_q != IDLE);
  assign redirect_pc    = redirect_pc_q;
  assign trap_pc        = trap_pc_q;
  assign trap_cause     = trap_cause_q;
  assign drain_timeout  = timeout_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed cases plus random traps,
// checked every cycle against a transaction-level timeline model.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_is_ecall, ex_is_mret;
`ifdef TRAP_EBREAK_EN
  logic        ex_is_ebreak;
`endif
  logic [31:0] ex_pc, mepc, mtvec;
  logic        mem_busy;
  logic        stall, flush, redirect_valid, csr_trap_we, busy, drain_timeout;
  logic [31:0] redirect_pc, trap_pc, trap_cause;

  trap_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_is_ecall    (ex_is_ecall),
    .ex_is_mret     (ex_is_mret),
`ifdef TRAP_EBREAK_EN
    .ex_is_ebreak   (ex_is_ebreak),
`endif
    .ex_pc          (ex_pc),
    .mem_busy       (mem_busy),
    .mepc           (mepc),
    .mtvec          (mtvec),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .csr_trap_we    (csr_trap_we),
    .trap_pc        (trap_pc),
    .trap_cause     (trap_cause),
    .busy           (busy),
    .drain_timeout  (drain_timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m_tpc, m_cause, m_rpc;
  logic        m_to;
  bit          keep_csr;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // check one cycle at the falling edge, then advance past the rising edge
  task automatic step(logic e_stall, logic e_busy, logic e_we, logic e_rv);
    @(negedge clk);
    chk("stall", 32'(stall), 32'(e_stall));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("csr_trap_we", 32'(csr_trap_we), 32'(e_we));
    chk("redirect_valid", 32'(redirect_valid), 32'(e_rv));
    chk("flush", 32'(flush), 32'(e_rv));
    chk("trap_pc", trap_pc, m_tpc);
    chk("trap_cause", trap_cause, m_cause);
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("drain_timeout", 32'(drain_timeout), 32'(m_to));
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    ex_valid    = 1'($urandom);
    ex_is_ecall = 1'($urandom);
    ex_is_mret  = 1'($urandom);
`ifdef TRAP_EBREAK_EN
    ex_is_ebreak = 1'($urandom);
`endif
    ex_pc    = $urandom;
    mem_busy = 1'($urandom);
    if (!keep_csr) begin
      mepc  = $urandom;
      mtvec = $urandom;
    end
  endtask

  task automatic idle();
    noise();
    if (1'($urandom)) begin
      ex_valid = 1'b0;
    end else begin
      ex_is_ecall = 1'b0;
      ex_is_mret  = 1'b0;
`ifdef TRAP_EBREAK_EN
      ex_is_ebreak = 1'b0;
`endif
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ECALL/EBREAK path; mem_busy held high for the first nbusy DRAIN cycles
  task automatic do_trap(logic [31:0] pc, int nbusy, bit ec, bit eb, bit mr);
    int nd;
    noise();
    ex_valid    = 1'b1;
    ex_is_ecall = ec;
    ex_is_mret  = mr;
`ifdef TRAP_EBREAK_EN
    ex_is_ebreak = eb;
`endif
    ex_pc = pc;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    m_tpc   = pc;
    m_cause = ec ? 32'd11 : 32'd3;
    nd = (nbusy >= 15) ? 15 : nbusy + 1;
    for (int k = 0; k < nd; k++) begin
      noise();
      mem_busy = (k < nbusy);
      step(1'b1, 1'b1, 1'b0, 1'b0);
    end
    if (nbusy >= 15) m_to = 1'b1;
    noise();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    m_rpc = {mtvec[31:2], 2'b00};
    noise();
    step(1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic do_mret();
    noise();
    ex_valid    = 1'b1;
    ex_is_ecall = 1'b0;
    ex_is_mret  = 1'b1;
`ifdef TRAP_EBREAK_EN
    ex_is_ebreak = 1'b0;
`endif
    step(1'b1, 1'b0, 1'b0, 1'b0);
    m_rpc = {mepc[31:2], 2'b00};
    noise();
    step(1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic clear_model();
    m_tpc   = '0;
    m_cause = '0;
    m_rpc   = '0;
    m_to    = 1'b0;
  endtask

  initial begin
    int kind;
    bit eb;
    clear_model();
    keep_csr    = 1'b0;
    rst         = 1'b1;
    ex_valid    = 1'b0;
    ex_is_ecall = 1'b0;
    ex_is_mret  = 1'b0;
`ifdef TRAP_EBREAK_EN
    ex_is_ebreak = 1'b0;
`endif
    ex_pc    = '0;
    mem_busy = 1'b0;
    mepc     = '0;
    mtvec    = '0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle();

    keep_csr = 1'b1;
    mtvec    = 32'h805;
    do_trap(32'h100, 0, 1'b1, 1'b0, 1'b0);
    chk("ecall_rpc_0x804", m_rpc, 32'h804);
    do_trap($urandom, 4, 1'b1, 1'b0, 1'b0);
    mepc = 32'h204;
    do_mret();
    idle();
    do_trap($urandom, 2, 1'b1, 1'b0, 1'b1);
    do_trap($urandom, 40, 1'b1, 1'b0, 1'b0);
    idle();

    keep_csr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) idle();
      kind = int'($urandom_range(0, 3));
      eb   = 1'b0;
`ifdef TRAP_EBREAK_EN
      eb = 1'($urandom);
`endif
      case (kind)
        0: do_mret();
        1: do_trap($urandom, int'($urandom_range(0, 17)), 1'b1, eb, 1'b1);
        default: do_trap($urandom, int'($urandom_range(0, 17)), 1'b1, eb, 1'b0);
      endcase
    end

    // reset while draining aborts with no strobes and clears drain_timeout
    noise();
    ex_valid    = 1'b1;
    ex_is_ecall = 1'b1;
    ex_is_mret  = 1'b0;
`ifdef TRAP_EBREAK_EN
    ex_is_ebreak = 1'b0;
`endif
    ex_pc = 32'h300;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    m_tpc   = 32'h300;
    m_cause = 32'd11;
    noise();
    mem_busy = 1'b0;
    rst      = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    clear_model();
    rst = 1'b0;
    for (int j = 0; j < 4; j++) idle();

`ifdef TRAP_EBREAK_EN
    do_trap(32'h40, 1, 1'b0, 1'b1, 1'b0);
    chk("ebreak_cause", m_cause, 32'd3);
    do_trap(32'h44, 0, 1'b0, 1'b1, 1'b1);
    idle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
